// File: rtl/reg_bank_burst.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_burst
// Brief    : N x D register bank with a decoded single-write port, a
//            combinational read port and a valid/ready burst-load sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_burst #(
    parameter int N = 7,
    parameter int A = 3,
    parameter int D = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [A-1:0]   wr_addr,
    input  logic [D-1:0]   wr_data,
    input  logic           burst_start,
    input  logic [A-1:0]   burst_addr,
    input  logic [A-1:0]   burst_len,
    input  logic           in_valid,
    input  logic [D-1:0]   in_data,
    output logic           in_ready,
    input  logic [A-1:0]   rd_addr,
    output logic [D-1:0]   rd_data,
    output logic [N*D-1:0] q,
    output logic [N-1:0]   reg_valid,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [A-1:0] c_n    = A'(N);
    localparam logic [A-1:0] c_one  = A'(1);
    localparam logic [A-1:0] c_zero = '0;

    logic [1:0]   r_state;
    logic [1:0]   w_next_state;
    logic [A-1:0] r_ptr;
    logic [A-1:0] r_cnt;
    logic         r_err;

    logic         w_idle;
    logic         w_hs;
    logic         w_burst_addr_ok;
    logic         w_wr_addr_ok;
    logic         w_start_load;
    logic         w_start_empty;
    logic         w_reject;
    logic         w_single;
    logic [D-1:0] w_regs [N];

    assign w_idle          = (r_state == S_IDLE);
    assign w_hs            = (r_state == S_LOAD) && in_valid;
    assign w_burst_addr_ok = (burst_addr != c_zero) && (burst_addr <= c_n);
    assign w_wr_addr_ok    = (wr_addr != c_zero) && (wr_addr <= c_n);

    // An out-of-range start address is rejected even when the length is zero.
    assign w_start_load  = w_idle && burst_start && w_burst_addr_ok && (burst_len != c_zero);
    assign w_start_empty = w_idle && burst_start && w_burst_addr_ok && (burst_len == c_zero);
    assign w_reject      = w_idle && burst_start && !w_burst_addr_ok;
    assign w_single      = w_idle && wr_en && w_wr_addr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_load) begin
                    w_next_state = S_LOAD;
                end else if (w_start_empty) begin
                    w_next_state = S_DONE;
                end
            end
            S_LOAD: begin
                if (w_hs && (r_cnt == c_one)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= c_one;
            r_cnt <= c_zero;
        end else if (w_start_load) begin
            r_ptr <= burst_addr;
            r_cnt <= burst_len;
        end else if (w_hs) begin
            r_ptr <= (r_ptr == c_n) ? c_one : (r_ptr + c_one);
            r_cnt <= r_cnt - c_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_reject;
        end
    end

    assign err = r_err;

    // Single writes only happen in IDLE and stream writes only in LOAD,
    // so the two write sources never collide on the same register.
    for (genvar k = 0; k < N; k++) begin : g_reg
        localparam logic [A-1:0] c_addr = A'(k + 1);

        logic         r_reg;
        logic [D-1:0] r_word;
        logic         w_sel;
        logic [D-1:0] w_din;

        assign w_sel = (w_single && (wr_addr == c_addr)) || (w_hs && (r_ptr == c_addr));
        assign w_din = w_hs ? in_data : wr_data;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_word <= '0;
                r_reg  <= 1'b0;
            end else if (w_sel) begin
                r_word <= w_din;
                r_reg  <= 1'b1;
            end
        end

        assign w_regs[k]          = r_word;
        assign q[k*D +: D]        = r_word;
        assign reg_valid[k]       = r_reg;
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N; k++) begin
            if (rd_addr == A'(k + 1)) begin
                rd_data = w_regs[k];
            end
        end
    end

endmodule
`default_nettype wire
